// File: rtl/alu_result_stage.sv
// alu_result_stage
//   Write-back stage behind the 16-bit ALU. Each accepted ALU result is held
//   with its destination tag and write enable in a 2-entry FIFO. The FIFO
//   presents its head to the register-file write-back port through a
//   valid/ready handshake. The stage also keeps the architectural zero flag
//   and a count of retired results.
//
//   Ports
//     clk, rst                 clock; synchronous active-high reset
//     in_valid/in_ready        ALU-side handshake (in_ready = fewer than 2 held)
//     in_result, in_zf, in_rd  ALU result, zero flag, destination index
//     in_we, in_flag_we        register-file write enable, zero-flag update enable
//     out_valid/out_ready      write-back handshake
//     out_result, out_rd       head entry data and destination
//     out_we                   head entry write enable (0 whenever out_valid=0)
//     zero_flag                architectural zero flag, updated on push
//     retired_cnt              number of entries popped since reset (wraps)
module alu_result_stage #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_zf,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_we,
  input  logic              in_flag_we,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [ADDR_W-1:0] out_rd,
  output logic              out_we,
  output logic              zero_flag,
  output logic [CNT_W-1:0]  retired_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  occ_t              occ;

  // Head entry drives the write-back port directly; tail holds the second entry.
  logic [DATA_W-1:0] head_result;
  logic [ADDR_W-1:0] head_rd;
  logic              head_we;
  logic [DATA_W-1:0] tail_result;
  logic [ADDR_W-1:0] tail_rd;
  logic              tail_we;

  logic              push;
  logic              pop;

  // Handshake qualifiers depend only on registered occupancy, so in_ready
  // has no combinational path from out_ready.
  always_comb begin
    in_ready   = (occ != FULL);
    out_valid  = (occ != EMPTY);
    push       = in_valid & in_ready;
    pop        = out_valid & out_ready;
    out_result = head_result;
    out_rd     = head_rd;
    out_we     = head_we & out_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ         <= EMPTY;
      head_result <= '0;
      head_rd     <= '0;
      head_we     <= 1'b0;
      tail_result <= '0;
      tail_rd     <= '0;
      tail_we     <= 1'b0;
      zero_flag   <= 1'b0;
      retired_cnt <= '0;
    end else begin
      if (push && in_flag_we) begin
        zero_flag <= in_zf;
      end

      if (pop) begin
        retired_cnt <= retired_cnt + CNT_W'(1);
      end

      unique case (occ)
        EMPTY: begin
          if (push) begin
            head_result <= in_result;
            head_rd     <= in_rd;
            head_we     <= in_we;
            occ         <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            // Head retires and the new entry replaces it in the same cycle.
            head_result <= in_result;
            head_rd     <= in_rd;
            head_we     <= in_we;
          end else if (push) begin
            tail_result <= in_result;
            tail_rd     <= in_rd;
            tail_we     <= in_we;
            occ         <= FULL;
          end else if (pop) begin
            occ <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            head_result <= tail_result;
            head_rd     <= tail_rd;
            head_we     <= tail_we;
            occ         <= ONE;
          end
        end
        default: begin
          occ <= EMPTY;
        end
      endcase
    end
  end

endmodule
